// File: rtl/ru_os_pkg.sv
// rtl/ru_os_pkg.sv - shared FSM encoding, width helpers and operand word-index helpers
package ru_os_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_ALLOC    = 3'd1,
        S_FEED     = 3'd2,
        S_DRAIN    = 3'd3,
        S_WAIT_ACK = 3'd4
    } state_e;

    // Coordinate width that stays at least one bit for a single-row/column array
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int a_word(input int r, input int k, input int k_dim);
        return r * k_dim + k;
    endfunction

    function automatic int b_word(input int k, input int c, input int cols);
        return k * cols + c;
    endfunction

endpackage

// File: rtl/ru_fault_alloc.sv
// rtl/ru_fault_alloc.sv - column-major first-NUM_RU fault encoder; status outputs under RU_FAULT_STATUS_EN
module ru_fault_alloc
    import ru_os_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NUM_RU = 4,
    parameter int RW     = 2,
    parameter int CW     = 2,
    parameter int FCW    = 5
) (
    input  logic [ROWS*COLS-1:0] fault_map_i,
    output logic [NUM_RU-1:0]    en_o,
    output logic [NUM_RU*RW-1:0] row_o,
    output logic [NUM_RU*CW-1:0] col_o,
`ifdef RU_FAULT_STATUS_EN
    output logic [FCW-1:0]       fault_count_o,
    output logic [ROWS*COLS-1:0] unrepaired_o,
`endif
    output logic                 overflow_o
);

    always_comb begin
        int n;
        n          = 0;
        en_o       = '0;
        row_o      = '0;
        col_o      = '0;
        overflow_o = 1'b0;
`ifdef RU_FAULT_STATUS_EN
        unrepaired_o = '0;
`endif
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (!fault_map_i[r*COLS + c]) begin
                    if (n < NUM_RU) begin
                        en_o[n]           = 1'b1;
                        row_o[n*RW +: RW] = RW'(r);
                        col_o[n*CW +: CW] = CW'(c);
                    end else begin
                        overflow_o = 1'b1;
`ifdef RU_FAULT_STATUS_EN
                        unrepaired_o[r*COLS + c] = 1'b1;
`endif
                    end
                    n++;
                end
            end
        end
`ifdef RU_FAULT_STATUS_EN
        fault_count_o = FCW'(n);
`endif
    end

endmodule

// File: rtl/ru_scheduler_os.sv
// rtl/ru_scheduler_os.sv - lockstep recompute-unit scheduler for an output-stationary array
// Optional fault status outputs are enabled by defining RU_FAULT_STATUS_EN.
module ru_scheduler_os
    import ru_os_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_DIM     = 4,
    parameter int WORD_SIZE = 16,
    parameter int NUM_RU    = 4,
    parameter int RU_LAT    = 2,
    localparam int RW  = idx_w(ROWS),
    localparam int CW  = idx_w(COLS),
    localparam int KW  = $clog2(K_DIM + 1),
    localparam int LW  = $clog2(RU_LAT + 1),
    localparam int FCW = $clog2(ROWS*COLS + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ROWS*COLS-1:0]           fault_map,
    input  logic [ROWS*K_DIM*WORD_SIZE-1:0] left_matrix,
    input  logic [K_DIM*COLS*WORD_SIZE-1:0] top_matrix,
    input  logic [NUM_RU-1:0]              ru_result_ack,
    output logic [NUM_RU-1:0]              ru_en,
    output logic [NUM_RU*RW-1:0]           ru_row_mapping,
    output logic [NUM_RU*CW-1:0]           ru_col_mapping,
    output logic [NUM_RU*WORD_SIZE-1:0]    ru_left_inputs,
    output logic [NUM_RU*WORD_SIZE-1:0]    ru_top_inputs,
    output logic [NUM_RU-1:0]              ru_acc_clear,
    output logic [NUM_RU-1:0]              ru_output_valid,
`ifdef RU_FAULT_STATUS_EN
    output logic [FCW-1:0]                 fault_count,
    output logic [ROWS*COLS-1:0]           unrepaired_map,
`endif
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
);

    state_e                state_q;
    logic [ROWS*COLS-1:0]  fmap_q;
    logic [NUM_RU-1:0]     en_q, valid_q;
    logic [NUM_RU*RW-1:0]  row_q;
    logic [NUM_RU*CW-1:0]  col_q;
    logic [KW-1:0]         k_q;
    logic [LW-1:0]         lat_q;
    logic                  ovf_q, done_q;

    logic [NUM_RU-1:0]     alloc_en_d;
    logic [NUM_RU*RW-1:0]  alloc_row_d;
    logic [NUM_RU*CW-1:0]  alloc_col_d;
    logic                  alloc_ovf_d;
`ifdef RU_FAULT_STATUS_EN
    logic [FCW-1:0]        alloc_cnt_d, cnt_q;
    logic [ROWS*COLS-1:0]  alloc_unrep_d, unrep_q;
`endif

    ru_fault_alloc #(
        .ROWS(ROWS), .COLS(COLS), .NUM_RU(NUM_RU), .RW(RW), .CW(CW), .FCW(FCW)
    ) u_alloc (
        .fault_map_i   (fmap_q),
        .en_o          (alloc_en_d),
        .row_o         (alloc_row_d),
        .col_o         (alloc_col_d),
`ifdef RU_FAULT_STATUS_EN
        .fault_count_o (alloc_cnt_d),
        .unrepaired_o  (alloc_unrep_d),
`endif
        .overflow_o    (alloc_ovf_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            fmap_q  <= '0;
            en_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
            lat_q   <= '0;
            valid_q <= '0;
            done_q  <= 1'b0;
`ifdef RU_FAULT_STATUS_EN
            cnt_q   <= '0;
            unrep_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        fmap_q  <= fault_map;
                        state_q <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    en_q  <= alloc_en_d;
                    row_q <= alloc_row_d;
                    col_q <= alloc_col_d;
                    ovf_q <= alloc_ovf_d;
`ifdef RU_FAULT_STATUS_EN
                    cnt_q   <= alloc_cnt_d;
                    unrep_q <= alloc_unrep_d;
`endif
                    k_q <= '0;
                    if (alloc_en_d == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_FEED;
                    end
                end
                S_FEED: begin
                    // k saturates at the last index so it never wraps inside a job
                    if (k_q == KW'(K_DIM - 1)) begin
                        state_q <= S_DRAIN;
                        lat_q   <= '0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (lat_q == LW'(RU_LAT - 1)) begin
                        state_q <= S_WAIT_ACK;
                        valid_q <= en_q;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    valid_q <= valid_q & ~ru_result_ack;
                    if (valid_q == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        int r, c, k;
        ru_left_inputs = '0;
        ru_top_inputs  = '0;
        ru_acc_clear   = '0;
        r = 0;
        c = 0;
        k = int'(k_q);
        if (state_q == S_FEED) begin
            for (int i = 0; i < NUM_RU; i++) begin
                if (en_q[i]) begin
                    r = int'(row_q[i*RW +: RW]);
                    c = int'(col_q[i*CW +: CW]);
                    ru_left_inputs[i*WORD_SIZE +: WORD_SIZE] =
                        left_matrix[a_word(r, k, K_DIM)*WORD_SIZE +: WORD_SIZE];
                    ru_top_inputs[i*WORD_SIZE +: WORD_SIZE] =
                        top_matrix[b_word(k, c, COLS)*WORD_SIZE +: WORD_SIZE];
                    ru_acc_clear[i] = (k_q == '0);
                end
            end
        end
    end

    assign ru_en           = en_q;
    assign ru_row_mapping  = row_q;
    assign ru_col_mapping  = col_q;
    assign ru_output_valid = valid_q;
    assign overflow        = ovf_q;
    assign done            = done_q;
    assign busy            = (state_q != S_IDLE);
`ifdef RU_FAULT_STATUS_EN
    assign fault_count     = cnt_q;
    assign unrepaired_map  = unrep_q;
`endif

endmodule

// File: doc/ru_scheduler_os.md
RU_SCHEDULER_OS -- requirements
Module: ru_scheduler_os

Interface
REQ-001 Parameters (name, default, meaning): ROWS 4, array rows; COLS 4, array columns; K_DIM 4, inner (reduction) dimension; WORD_SIZE 16, operand width; NUM_RU 4, number of recompute units; RU_LAT 2, RU multiply-accumulate pipeline depth in cycles.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle job request.
REQ-005 fault_map  in  ROWS*COLS  STW result; bit r*COLS+c = 0 means PE(r,c) is faulty.
REQ-006 left_matrix  in  ROWS*K_DIM*WORD_SIZE  A operand; element (r,k) at word index r*K_DIM+k.
REQ-007 top_matrix  in  K_DIM*COLS*WORD_SIZE  B operand; element (k,c) at word index k*COLS+c.
REQ-008 ru_result_ack  in  NUM_RU  per-RU consumer acknowledge of the result.
REQ-009 ru_en  out  NUM_RU  RU i is allocated to a faulty PE.
REQ-010 ru_row_mapping / ru_col_mapping  out  NUM_RU*clog2(ROWS) / NUM_RU*clog2(COLS)  coordinates of the PE repaired by RU i.
REQ-011 ru_left_inputs / ru_top_inputs  out  NUM_RU*WORD_SIZE  per-RU operand buses.
REQ-012 ru_acc_clear  out  NUM_RU  clears the RU accumulator together with the first operand pair.
REQ-013 ru_output_valid  out  NUM_RU  RU result valid, held until acknowledged.
REQ-014 busy, done, overflow  out  1 each  job in progress; one-cycle completion pulse; faults exceed NUM_RU.

Function
REQ-015 FSM states: IDLE, ALLOC, FEED, DRAIN, WAIT_ACK; the FSM is global and all allocated RUs run in lockstep.
REQ-016 IDLE: start=1 SHALL capture fault_map and go to ALLOC; start while busy=1 SHALL be ignored.
REQ-017 ALLOC (1 cycle): faults SHALL be assigned to RU 0,1,... in column-major order (c outer, r inner); ru_en and the mappings SHALL be registered; overflow=1 if the fault count exceeds NUM_RU, and the excess faults SHALL be left unrepaired.
REQ-018 Zero faults: ALLOC SHALL go directly to IDLE with done pulsed on the next cycle, and ru_en SHALL stay 0.
REQ-019 FEED lasts K_DIM cycles, k=0..K_DIM-1; for each enabled RU i: left=A[row_i][k], top=B[k][col_i]; ru_acc_clear[i]=1 only at k=0.
REQ-020 The first operand pair SHALL appear on the outputs 2 cycles after the start edge; disabled RUs and all non-FEED states SHALL drive zero operands.
REQ-021 The k counter SHALL be clog2(K_DIM+1) bits wide and SHALL NOT wrap within a job; K_DIM=1 SHALL give exactly one FEED cycle.
REQ-022 DRAIN SHALL last RU_LAT cycles, after which ru_output_valid SHALL be set for every enabled RU.
REQ-023 WAIT_ACK: ru_output_valid[i] SHALL clear on the cycle after ru_result_ack[i]=1; ack on a non-valid RU SHALL be ignored.
REQ-024 When all valid bits are clear, the FSM SHALL return to IDLE, pulse done for 1 cycle and drop busy; ru_en and the mappings SHALL hold until the next start.
REQ-025 busy=1 in every state except IDLE.

Reset
REQ-026 rst=1 SHALL immediately force IDLE and zero all outputs, counters and the captured fault map, including in the middle of a job; there is no partial-result recovery.

Configuration
REQ-027 Macro RU_FAULT_STATUS_EN defined: adds outputs fault_count (clog2(ROWS*COLS+1) bits, total faults captured) and unrepaired_map (ROWS*COLS bits, 1 = faulty PE not assigned to an RU), registered in ALLOC and reset to 0.
REQ-028 Macro RU_FAULT_STATUS_EN undefined: these ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Shared package ru_os_pkg SHALL hold the FSM state encoding, the word-index helper functions for the A and B layouts, and the width localparams.
REQ-030 Sub-module ru_fault_alloc (combinational column-major first-NUM_RU fault encoder) SHALL produce the enables, mappings and overflow, registered by the parent.

Verification
REQ-031 Single fault: 4x4, K_DIM=4, fault_map bit 9=0 -> ru_en=0001, row 2, col 1; A[2][0..3] and B[0..3][1] on RU0 for 4 cycles starting at start+2; ru_output_valid[0] at start+2+4+RU_LAT.
REQ-032 Five faults at bits 0,4,8,12,1 -> ru_en=1111, overflow=1, RU3 mapped to (3,0); with the macro defined, fault_count=5 and unrepaired_map=bit 1 only.
REQ-033 fault_map all ones -> done pulses 2 cycles after start; ru_en=0; no operands driven.
REQ-034 rst asserted during FEED k=2 -> all outputs 0 without waiting for a clock edge; a new start after release runs a full job.
REQ-035 Hold ru_result_ack=0 for 10 cycles -> valid stays high and start is ignored; ack=1 -> valid clears, then done for 1 cycle.
REQ-036 K_DIM=1, ROWS=2, COLS=8 with a fault at (1,7) -> one FEED cycle with A[1][0] and B[0][7]; col map 7 is 3 bits wide and row map 1 is 1 bit wide.
